serial_adder_ctrl: RTL
======================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, with synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1, a request to add a and b; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH, operand A; captured at the accepting edge.
REQ-006 SHALL have port b, input, WIDTH, operand B; captured at the accepting edge.
REQ-007 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-008 SHALL have port done, output, 1, a one-cycle pulse marking sum/cout valid.
REQ-009 SHALL have port sum, output, WIDTH, the registered result (a+b) mod 2^WIDTH.
REQ-010 SHALL have port cout, output, 1, the registered carry-out of a+b.

Function
REQ-011 SHALL be a three-state FSM: IDLE, ADD, DONE.
REQ-012 SHALL take IDLE->ADD on an edge with start=1; at that edge it latches a and b into shift registers, clears the bit counter and the carry flop, and clears sum and cout.
REQ-013 SHALL, in ADD, process one bit per cycle, LSB first, through a single shared 1-bit full-add datapath.
REQ-014 SHALL build the full-add datapath from two half-adder stages: s1=a_i^b_i, c1=a_i&b_i, s=s1^cin, c2=s1&cin, cout_i=c1|c2.
REQ-015 SHALL shift sum right once per ADD cycle with the new bit inserted at the MSB, so that after WIDTH shifts bit 0 is the LSB result.
REQ-016 SHALL take ADD->DONE after exactly WIDTH ADD cycles; the counter runs 0..WIDTH-1 and the final carry loads cout.
REQ-017 SHALL assert done for exactly the one cycle spent in DONE, then take DONE->IDLE unconditionally.
REQ-018 SHALL have a latency of WIDTH+1 cycles from the accepting edge to done=1 (done is visible WIDTH+1 edges after start is sampled).
REQ-019 SHALL hold sum and cout stable from DONE until the next accepted start.
REQ-020 SHALL ignore start while in ADD or DONE, with no queueing and no effect on the operation in flight.
REQ-021 SHALL ignore changes on a and b after the accepting edge.
REQ-022 SHALL accept start asserted in the cycle that immediately follows DONE (now IDLE), giving a back-to-back throughput of one add per WIDTH+2 cycles.
REQ-023 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-024 SHALL, on an edge with rst=1, set state=IDLE, busy=0, done=0, sum=0, cout=0, and clear the counter, carry and shift registers.
REQ-025 SHALL give rst priority over start at the same edge.
REQ-026 SHALL, when rst occurs mid-ADD or in DONE, abort the operation with no done pulse and no partial result visible.

Structure
REQ-027 SHALL take the state encodings (IDLE=2'd0, ADD=2'd1, DONE=2'd2) and the default WIDTH constant from the shared package serial_add_pkg.
REQ-028 SHALL instantiate the existing half_adder module twice, as the sole datapath sub-module, to form the 1-bit full add.
REQ-029 SHALL size the bit counter as $clog2(WIDTH) bits.

Verification (WIDTH=8)
REQ-030 SHALL cover: a=8'h00, b=8'h00, start pulse -> done after 9 edges, sum=8'h00, cout=0, busy high for 9 cycles.
REQ-031 SHALL cover: a=8'hFF, b=8'h01 -> sum=8'h00, cout=1; a=8'hFF, b=8'hFF -> sum=8'hFE, cout=1.
REQ-032 SHALL cover: a=8'hA5, b=8'h5A, with a/b changed to 8'h00 one cycle after start -> sum=8'hFF, cout=0.
REQ-033 SHALL cover: start re-pulsed at ADD cycle 3 with a=8'h01, b=8'h01 -> ignored; the first result is delivered and exactly one done pulse occurs.
REQ-034 SHALL cover: rst at ADD cycle 4 -> next cycle busy=0, sum=0, cout=0, no done; a new start then gives 8'h0F+8'h01 -> 8'h10, cout=0.
REQ-035 SHALL cover: start held high continuously -> adds repeat every 10 cycles, with done pulses 10 cycles apart.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared constants and FSM state encoding for the bit-serial adder.
package serial_add_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/half_adder.sv
// One-bit half adder: sum and carry of two input bits.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: captures two operands, adds them LSB first over WIDTH cycles
// through one shared full-add slice, then pulses done with registered sum/cout.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, b_sr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic               last_bit;

  logic s1, c1, s_bit, c2, cout_bit;

  // Full add built from two half-adder stages on the current LSBs.
  half_adder u_ha_ab (
    .a (a_sr_q[0]),
    .b (b_sr_q[0]),
    .s (s1),
    .c (c1)
  );

  half_adder u_ha_cin (
    .a (s1),
    .b (carry_q),
    .s (s_bit),
    .c (c2)
  );

  assign cout_bit = c1 | c2;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Status flags are decoded from next state so they are true flop outputs.
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
          end
        end
        ADD: begin
          a_sr_q  <= a_sr_q >> 1;
          b_sr_q  <= b_sr_q >> 1;
          sum     <= {s_bit, sum[WIDTH-1:1]};
          carry_q <= cout_bit;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_bit) cout <= cout_bit;
        end
        default: ;
      endcase
    end
  end

endmodule
